// File: rtl/warp_issue_arbiter_if.sv
// Issue-stage arbiter bus: instruction buffers, scoreboard, operand collector,
// writeback and fetch-throttle signals, grouped into one bundle.
//   slave  : the arbiter side (samples requests/readiness/writebacks, drives grants)
//   master : the surrounding pipeline (drives requests, observes grants)
// Signals:
//   req_IB_IU      [NUM_WARPS]  warp buffer holds a valid head instruction
//   ready_SB_IU    [NUM_WARPS]  scoreboard reports no hazard on that head
//   ready_OC_IU                 operand collector can accept an issue
//   done_WB_IU     [NUM_WARPS]  one instruction of the warp completed (1-cycle pulse)
//   grant_IU_IB    [NUM_WARPS]  one-hot issue grant to the buffers
//   valid_IU_OC                 an issue happens this cycle
//   warp_id_IU_OC  [WID_W]      granted warp id (0 when not valid)
//   credit_full_IU [NUM_WARPS]  warp has the maximum number of instructions in flight
interface warp_issue_arbiter_if #(
  parameter int NUM_WARPS = 8
);
  localparam int WID_W = $clog2(NUM_WARPS);

  logic [NUM_WARPS-1:0] req_IB_IU;
  logic [NUM_WARPS-1:0] ready_SB_IU;
  logic                 ready_OC_IU;
  logic [NUM_WARPS-1:0] done_WB_IU;
  logic [NUM_WARPS-1:0] grant_IU_IB;
  logic                 valid_IU_OC;
  logic [WID_W-1:0]     warp_id_IU_OC;
  logic [NUM_WARPS-1:0] credit_full_IU;

  modport master (
    output req_IB_IU, ready_SB_IU, ready_OC_IU, done_WB_IU,
    input  grant_IU_IB, valid_IU_OC, warp_id_IU_OC, credit_full_IU
  );

  modport slave (
    input  req_IB_IU, ready_SB_IU, ready_OC_IU, done_WB_IU,
    output grant_IU_IB, valid_IU_OC, warp_id_IU_OC, credit_full_IU
  );
endinterface

// File: rtl/warp_issue_arbiter.sv
// Issue-stage scheduler: each cycle grants at most one warp whose buffer holds a
// hazard-free head instruction, round-robin from rr_ptr, with per-warp in-flight
// credit counters that block a warp once MAX_INFLIGHT instructions are outstanding.
// Grant is combinational from registered state and current inputs.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-high; all outputs read 0 while asserted
//   bus  : warp_issue_arbiter_if.slave (requests, readiness, writebacks, grants)
// Build option:
//   GTO_GREEDY_EN defined   : re-grant the last issued warp while it stays eligible,
//                             otherwise fall back to the round-robin scan.
//   GTO_GREEDY_EN undefined : pure round-robin.
module warp_issue_arbiter #(
  parameter int NUM_WARPS    = 8,
  parameter int MAX_INFLIGHT = 4
) (
  input logic                 clk,
  input logic                 rst,
  warp_issue_arbiter_if.slave bus
);
  localparam int WID_W = $clog2(NUM_WARPS);
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned NW = NUM_WARPS;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_INFLIGHT);
  localparam logic [WID_W-1:0] LAST_IDX = WID_W'(NUM_WARPS - 1);

  logic [WID_W-1:0]     rr_ptr;
  logic [CNT_W-1:0]     cnt [NUM_WARPS];
  logic [NUM_WARPS-1:0] eligible;
  logic [NUM_WARPS-1:0] full;
  logic [NUM_WARPS-1:0] grant;
  logic [WID_W-1:0]     sel;
  logic [WID_W-1:0]     rr_next;
  logic                 found;
`ifdef GTO_GREEDY_EN
  logic [WID_W-1:0]     last_wid;
  logic                 last_vld;
  logic                 greedy;
`endif

  always_comb begin
    eligible = '0;
    full     = '0;
    for (int unsigned w = 0; w < NW; w++) begin
      full[w]     = (cnt[w] == CNT_MAX);
      eligible[w] = bus.req_IB_IU[w] & bus.ready_SB_IU[w] & ~full[w];
    end
  end

  always_comb begin
    logic [WID_W-1:0] cand;
    found = 1'b0;
    sel   = '0;
    cand  = '0;
`ifdef GTO_GREEDY_EN
    greedy = 1'b0;
    if (last_vld && eligible[last_wid]) begin
      found  = 1'b1;
      greedy = 1'b1;
      sel    = last_wid;
    end
`endif
    for (int unsigned i = 0; i < NW; i++) begin
      // modulo keeps the scan correct for non-power-of-2 warp counts
      cand = WID_W'((32'(rr_ptr) + i) % NW);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    grant = '0;
    if (found && bus.ready_OC_IU && !rst) begin
      grant[sel] = 1'b1;
    end
  end

  assign rr_next = (sel == LAST_IDX) ? '0 : sel + 1'b1;

  assign bus.grant_IU_IB    = grant;
  assign bus.valid_IU_OC    = |grant;
  assign bus.warp_id_IU_OC  = (|grant) ? sel : '0;
  assign bus.credit_full_IU = full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      for (int unsigned w = 0; w < NW; w++) begin
        cnt[w] <= '0;
      end
`ifdef GTO_GREEDY_EN
      last_wid <= '0;
      last_vld <= 1'b0;
`endif
    end else begin
`ifdef GTO_GREEDY_EN
      // a stalled operand collector freezes the greedy history as well
      if (|grant) begin
        last_wid <= sel;
        last_vld <= 1'b1;
        if (!greedy) begin
          rr_ptr <= rr_next;
        end
      end else if (bus.ready_OC_IU) begin
        last_vld <= 1'b0;
      end
`else
      if (|grant) begin
        rr_ptr <= rr_next;
      end
`endif
      for (int unsigned w = 0; w < NW; w++) begin
        if (grant[w] && !bus.done_WB_IU[w]) begin
          cnt[w] <= cnt[w] + 1'b1;
        end else if (!grant[w] && bus.done_WB_IU[w] && (cnt[w] != '0)) begin
          cnt[w] <= cnt[w] - 1'b1;
        end
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      for (int unsigned w = 0; w < NW; w++) begin
        if (bus.done_WB_IU[w] && !grant[w] && (cnt[w] == '0)) begin
          $error("writeback on warp %0d with no instruction in flight", w);
        end
      end
    end
  end
`endif
endmodule
